// File: rtl/sram_test_pkg.sv
// Shared types for the SRAM march tester: modes, FSM states, element descriptors.
// Latency: n/a (types and constant tables only).
// Backpressure: n/a.
package sram_test_pkg;

  localparam logic MODE_ADDR   = 1'b0;
  localparam logic MODE_MARCHX = 1'b1;

  // IDLE/SETUP/STROBE/HOLD are access phases; NEXT marks the sequencer as
  // stepping through accesses (the advance happens on HOLD's closing edge).
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  // Data select per op: background, inverted background, or address.
  typedef enum logic [1:0] {
    DSEL_B  = 2'd0,
    DSEL_NB = 2'd1,
    DSEL_A  = 2'd2
  } dsel_t;

  typedef struct packed {
    logic  dir_down;   // 1 = walk 2^AW-1 down to 0
    logic  [1:0] nops; // 1 or 2 ops per address
    logic  op0_rd;     // 1 = read/compare, 0 = write
    dsel_t op0_dsel;
    logic  op1_rd;
    dsel_t op1_dsel;
  } elem_t;

  localparam elem_t ADDR_TBL [0:1] = '{
    '{dir_down:1'b0, nops:2'd1, op0_rd:1'b0, op0_dsel:DSEL_A, op1_rd:1'b0, op1_dsel:DSEL_A},
    '{dir_down:1'b0, nops:2'd1, op0_rd:1'b1, op0_dsel:DSEL_A, op1_rd:1'b0, op1_dsel:DSEL_A}
  };

  // up(w B); up(r B, w ~B); down(r ~B, w B); up(r B)
  localparam elem_t MARCHX_TBL [0:3] = '{
    '{dir_down:1'b0, nops:2'd1, op0_rd:1'b0, op0_dsel:DSEL_B,  op1_rd:1'b0, op1_dsel:DSEL_B},
    '{dir_down:1'b0, nops:2'd2, op0_rd:1'b1, op0_dsel:DSEL_B,  op1_rd:1'b0, op1_dsel:DSEL_NB},
    '{dir_down:1'b1, nops:2'd2, op0_rd:1'b1, op0_dsel:DSEL_NB, op1_rd:1'b0, op1_dsel:DSEL_B},
    '{dir_down:1'b0, nops:2'd1, op0_rd:1'b1, op0_dsel:DSEL_B,  op1_rd:1'b0, op1_dsel:DSEL_B}
  };

  function automatic elem_t get_elem(input logic mode, input logic [1:0] idx);
    if (mode == MODE_MARCHX) return MARCHX_TBL[idx];
    return ADDR_TBL[idx[0]];
  endfunction

  function automatic logic [1:0] elem_last(input logic mode);
    return (mode == MODE_ADDR) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/sram_march_tester_if.sv
// Control, status and SRAM pin bundle of the march tester.
// Latency: n/a (wiring only).
// Backpressure: none; go is a level sampled only when the tester is idle.
interface sram_march_tester_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  logic          go;
  logic          mode;
  logic [DW-1:0] background;
  logic          stop_on_error;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_drive;
  logic [DW-1:0] sram_rdata;
  logic          we_n;
  logic          oe_n;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_got;
  logic [DW-1:0] first_err_exp;

  modport master (
    input  go, mode, background, stop_on_error, sram_rdata,
    output sram_addr, sram_wdata, sram_drive, we_n, oe_n,
           busy, done, pass, err_count, first_err_addr, first_err_got, first_err_exp
  );

  modport slave (
    output go, mode, background, stop_on_error, sram_rdata,
    input  sram_addr, sram_wdata, sram_drive, we_n, oe_n,
           busy, done, pass, err_count, first_err_addr, first_err_got, first_err_exp
  );
endinterface

// File: rtl/sram_access_cycle.sv
// One asynchronous-SRAM access: SETUP (1) / STROBE (WAIT) / HOLD (1).
// Latency: WAIT+2 cycles per access; done_o is high during HOLD.
// Backpressure: a new start_i is taken in IDLE or in HOLD (back-to-back).
module sram_access_cycle
  import sram_test_pkg::*;
#(
  parameter int AW   = 18,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] sram_rdata_i,
  output logic [AW-1:0] sram_addr_o,
  output logic [DW-1:0] sram_wdata_o,
  output logic          sram_drive_o,
  output logic          we_n_o,
  output logic          oe_n_o,
  output logic          done_o,
  output logic [DW-1:0] rdata_o
);

  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

  state_t        phase_q, phase_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;

  // Phase register and latched access descriptor.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // Phase sequencing; a start in HOLD chains straight into the next SETUP.
  always_comb begin
    phase_d = phase_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (phase_q)
      ST_SETUP: begin
        phase_d = ST_STROBE;
        wcnt_d  = CW'(WAIT - 1);
      end
      ST_STROBE: begin
        if (wcnt_q == '0) phase_d = ST_HOLD;
        else              wcnt_d  = wcnt_q - CW'(1);
      end
      ST_HOLD: phase_d = ST_IDLE;
      default: phase_d = ST_IDLE;
    endcase
    if (start_i && (phase_q == ST_IDLE || phase_q == ST_HOLD)) begin
      phase_d = ST_SETUP;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      wr_d    = wr_i;
    end
  end

  // Strobes decode straight from the phase register so reset drops them at once.
  always_comb begin
    sram_drive_o = wr_q && (phase_q == ST_SETUP || phase_q == ST_STROBE || phase_q == ST_HOLD);
    we_n_o       = !(wr_q && phase_q == ST_STROBE);
    oe_n_o       = !(!wr_q && (phase_q == ST_STROBE || phase_q == ST_HOLD));
    done_o       = (phase_q == ST_HOLD);
  end

  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign rdata_o      = sram_rdata_i;

endmodule

// File: rtl/sram_march_tester.sv
// SRAM test engine: address-in-data or March X, with read checker and first-error capture.
// Latency: WAIT+2 cycles per access, plus 2 cycles for go acceptance and finish.
// Backpressure: go is ignored while busy; results held until the next accepted go.
module sram_march_tester
  import sram_test_pkg::*;
#(
  parameter int AW   = 18,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input  logic             clk,
  input  logic             clr,
  sram_march_tester_if.master bus
);

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic          stop_q, stop_d;
  logic [DW-1:0] bg_q, bg_d;
  logic [1:0]    elem_q, elem_d;
  logic          op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   err_q, err_d;
  logic [AW-1:0] fea_q, fea_d;
  logic [DW-1:0] feg_q, feg_d;
  logic [DW-1:0] fee_q, fee_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  elem_t         cur_e, adv_e, nx_e;
  dsel_t         cur_sel;
  logic          cur_rd;
  logic [DW-1:0] cur_dat;
  logic          mismatch;
  logic          last_op, last_addr, last_elem, seq_end;
  logic          nx_op;
  logic [1:0]    nx_elem;
  logic [AW-1:0] nx_ad;

  logic          acc_start, acc_wr, acc_done;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata, acc_rdata;

  function automatic logic [DW-1:0] sel_dat(input dsel_t s, input logic [DW-1:0] b,
                                            input logic [AW-1:0] a);
    case (s)
      DSEL_NB: return ~b;
      DSEL_A:  return DW'(a);
      default: return b;
    endcase
  endfunction

  sram_access_cycle #(.AW(AW), .DW(DW), .WAIT(WAIT)) u_acc (
    .clk          (clk),
    .clr          (clr),
    .start_i      (acc_start),
    .wr_i         (acc_wr),
    .addr_i       (acc_addr),
    .wdata_i      (acc_wdata),
    .sram_rdata_i (bus.sram_rdata),
    .sram_addr_o  (bus.sram_addr),
    .sram_wdata_o (bus.sram_wdata),
    .sram_drive_o (bus.sram_drive),
    .we_n_o       (bus.we_n),
    .oe_n_o       (bus.oe_n),
    .done_o       (acc_done),
    .rdata_o      (acc_rdata)
  );

  // Sequencer position, latched test setup and result registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADDR;
      stop_q  <= 1'b0;
      bg_q    <= '0;
      elem_q  <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      err_q   <= '0;
      fea_q   <= '0;
      feg_q   <= '0;
      fee_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      bg_q    <= bg_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      feg_q   <= feg_d;
      fee_q   <= fee_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Decode the current op and compare read data against the expected word.
  always_comb begin
    cur_e    = get_elem(mode_q, elem_q);
    cur_rd   = op_q ? cur_e.op1_rd : cur_e.op0_rd;
    cur_sel  = op_q ? cur_e.op1_dsel : cur_e.op0_dsel;
    cur_dat  = sel_dat(cur_sel, bg_q, addr_q);
    mismatch = acc_done && cur_rd && (acc_rdata != cur_dat);
  end

  // Advance order: op first, then address, then element (fresh start address).
  always_comb begin
    last_op   = (cur_e.nops == 2'd1) || op_q;
    last_addr = cur_e.dir_down ? (addr_q == '0) : (addr_q == '1);
    last_elem = (elem_q == elem_last(mode_q));
    seq_end   = last_op && last_addr && last_elem;
    nx_op     = 1'b0;
    nx_elem   = elem_q;
    nx_ad     = addr_q;
    adv_e     = get_elem(mode_q, elem_q + 2'd1);
    if (!last_op) begin
      nx_op = 1'b1;
    end else if (!last_addr) begin
      nx_ad = cur_e.dir_down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
    end else begin
      nx_elem = elem_q + 2'd1;
      nx_ad   = adv_e.dir_down ? '1 : '0;
    end
  end

  // Top-level FSM: accept go, issue accesses back-to-back, check, finish.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    stop_d    = stop_q;
    bg_d      = bg_q;
    elem_d    = elem_q;
    op_d      = op_q;
    addr_d    = addr_q;
    err_d     = err_q;
    fea_d     = fea_q;
    feg_d     = feg_q;
    fee_d     = fee_q;
    done_d    = done_q;
    pass_d    = pass_q;
    nx_e      = '0;
    acc_start = 1'b0;
    acc_wr    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          mode_d    = bus.mode;
          bg_d      = bus.background;
          stop_d    = bus.stop_on_error;
          err_d     = '0;
          fea_d     = '0;
          feg_d     = '0;
          fee_d     = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          elem_d    = '0;
          op_d      = 1'b0;
          addr_d    = '0;
          nx_e      = get_elem(bus.mode, 2'd0);
          acc_start = 1'b1;
          acc_wr    = !nx_e.op0_rd;
          acc_wdata = sel_dat(nx_e.op0_dsel, bus.background, '0);
          state_d   = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (acc_done) begin
          if (mismatch) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == '0) begin
              fea_d = addr_q;
              feg_d = acc_rdata;
              fee_d = cur_dat;
            end
          end
          if (seq_end || (mismatch && stop_q)) begin
            state_d = ST_FINISH;
          end else begin
            elem_d    = nx_elem;
            op_d      = nx_op;
            addr_d    = nx_ad;
            nx_e      = get_elem(mode_q, nx_elem);
            acc_start = 1'b1;
            acc_wr    = !(nx_op ? nx_e.op1_rd : nx_e.op0_rd);
            acc_addr  = nx_ad;
            acc_wdata = sel_dat(nx_op ? nx_e.op1_dsel : nx_e.op0_dsel, bg_q, nx_ad);
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_err_addr = fea_q;
  assign bus.first_err_got  = feg_q;
  assign bus.first_err_exp  = fee_q;

endmodule

// File: tb/tb_sram_march_tester.sv
// Directed bench for sram_march_tester with a small behavioural SRAM and fault knobs.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_march_tester;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int WAIT = 1;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  sram_march_tester_if #(.AW(AW), .DW(DW)) bif ();

  sram_march_tester #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bif)
  );

  // Behavioural SRAM: optional stuck-at-1 on bit 3 of word 5, optional aliasing of addr bit 3.
  logic [DW-1:0] mem [16];
  logic          stuck_en, alias_en, fill_req;
  logic [DW-1:0] fill_val;
  logic [3:0]    ridx;

  assign ridx = alias_en ? {1'b0, bif.sram_addr[2:0]} : bif.sram_addr;
  assign bif.sram_rdata = bif.oe_n ? '0 :
                          (mem[ridx] | ((stuck_en && ridx == 4'd5) ? 8'h08 : 8'h00));

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= fill_val;
    end else if (!bif.we_n && bif.sram_drive) begin
      mem[ridx] <= bif.sram_wdata;
    end
  end

  // Strobe pulse log: {is_read, address}.
  int         wr_pulses, rd_pulses;
  logic [4:0] trace [$];
  always @(negedge bif.we_n) begin
    wr_pulses++;
    trace.push_back({1'b0, bif.sram_addr});
  end
  always @(negedge bif.oe_n) begin
    rd_pulses++;
    trace.push_back({1'b1, bif.sram_addr});
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic mem_fill(input logic [DW-1:0] v);
    fill_val = v;
    fill_req = 1'b1;
    @(posedge clk);
    #1 fill_req = 1'b0;
  endtask

  // Start a test and count edges from the go-sampling edge (1) until done is seen.
  task automatic run(input logic m, input logic [DW-1:0] bg, input logic soe,
                     input int glitch_at, output int cyc);
    bif.mode = m;
    bif.background = bg;
    bif.stop_on_error = soe;
    wr_pulses = 0;
    rd_pulses = 0;
    trace.delete();
    @(negedge clk);
    bif.go = 1'b1;
    @(posedge clk);
    #1;
    bif.go = 1'b0;
    cyc = 1;
    // These are latched on go, so scrambling them must not matter.
    bif.mode = ~m;
    bif.background = ~bg;
    bif.stop_on_error = ~soe;
    while (!bif.done && cyc < 2000) begin
      bif.go = (cyc == glitch_at);
      @(posedge clk);
      cyc++;
      #1;
    end
    bif.go = 1'b0;
    check("done_reached", 32'(bif.done), 1);
  endtask

  int         cyc, bad, cnt;
  logic [4:0] exp_q [$];

  initial begin
    clr = 1'b1;
    bif.go = 1'b0;
    bif.mode = 1'b0;
    bif.background = '0;
    bif.stop_on_error = 1'b0;
    stuck_en = 1'b0;
    alias_en = 1'b0;
    fill_req = 1'b0;
    fill_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bif.busy), 0);
    check("rst_done", 32'(bif.done), 0);
    check("rst_pass", 32'(bif.pass), 0);
    check("rst_err", 32'(bif.err_count), 0);
    check("rst_we_n", 32'(bif.we_n), 1);
    check("rst_oe_n", 32'(bif.oe_n), 1);
    check("rst_drive", 32'(bif.sram_drive), 0);
    check("rst_addr", 32'(bif.sram_addr), 0);
    check("rst_wdata", 32'(bif.sram_wdata), 0);
    check("rst_fe", 32'({bif.first_err_addr, bif.first_err_got, bif.first_err_exp}), 0);
    @(negedge clk);
    clr = 1'b0;

    // Address-in-data on ideal memory.
    mem_fill(8'hFF);
    run(1'b0, 8'h00, 1'b0, 0, cyc);
    check("m0_cycles", cyc, 98);
    check("m0_pass", 32'(bif.pass), 1);
    check("m0_err", 32'(bif.err_count), 0);
    check("m0_busy", 32'(bif.busy), 0);
    check("m0_wr", wr_pulses, 16);
    check("m0_rd", rd_pulses, 16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != 8'(i)) bad++;
    check("m0_mem", bad, 0);
    repeat (3) @(posedge clk);
    #1;
    check("m0_done_held", 32'(bif.done), 1);

    // March X, background 55, with a go pulse mid-run that must be ignored.
    mem_fill(8'h00);
    run(1'b1, 8'h55, 1'b0, 40, cyc);
    check("mx_cycles", cyc, 290);
    check("mx_pass", 32'(bif.pass), 1);
    check("mx_err", 32'(bif.err_count), 0);
    exp_q.delete();
    for (int a = 0; a < 16; a++) exp_q.push_back({1'b0, 4'(a)});
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back({1'b1, 4'(a)});
      exp_q.push_back({1'b0, 4'(a)});
    end
    for (int a = 15; a >= 0; a--) begin
      exp_q.push_back({1'b1, 4'(a)});
      exp_q.push_back({1'b0, 4'(a)});
    end
    for (int a = 0; a < 16; a++) exp_q.push_back({1'b1, 4'(a)});
    check("mx_len", trace.size(), 96);
    bad = 0;
    for (int i = 0; i < 96 && i < trace.size(); i++) if (trace[i] != exp_q[i]) bad++;
    check("mx_order", bad, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != 8'h55) bad++;
    check("mx_mem", bad, 0);

    // Stuck-at-1 bit 3 at word 5, run to completion.
    stuck_en = 1'b1;
    mem_fill(8'h00);
    run(1'b1, 8'h55, 1'b0, 0, cyc);
    check("sa_err", 32'(bif.err_count), 2);
    check("sa_pass", 32'(bif.pass), 0);
    check("sa_fe_addr", 32'(bif.first_err_addr), 5);
    check("sa_fe_got", 32'(bif.first_err_got), 'h5D);
    check("sa_fe_exp", 32'(bif.first_err_exp), 'h55);

    // Same fault, stop at the first mismatch (element 2, address 5).
    mem_fill(8'h00);
    run(1'b1, 8'h55, 1'b1, 0, cyc);
    check("soe_cycles", cyc, 83);
    check("soe_err", 32'(bif.err_count), 1);
    check("soe_wr", wr_pulses, 21);
    check("soe_rd", rd_pulses, 6);
    check("soe_fe_addr", 32'(bif.first_err_addr), 5);
    repeat (5) @(posedge clk);
    #1;
    check("soe_quiet", wr_pulses + rd_pulses, 27);
    stuck_en = 1'b0;

    // Address bit 3 aliasing, address-in-data.
    alias_en = 1'b1;
    mem_fill(8'h00);
    run(1'b0, 8'h00, 1'b0, 0, cyc);
    check("al_err", 32'(bif.err_count), 8);
    check("al_pass", 32'(bif.pass), 0);
    check("al_fe_addr", 32'(bif.first_err_addr), 0);
    check("al_fe_got", 32'(bif.first_err_got), 'h08);
    check("al_fe_exp", 32'(bif.first_err_exp), 'h00);
    alias_en = 1'b0;

    // clr while a write strobe is active.
    bif.mode = 1'b0;
    @(negedge clk);
    bif.go = 1'b1;
    @(posedge clk);
    #1;
    bif.go = 1'b0;
    cnt = 0;
    while (!(bif.we_n == 1'b0 && bif.sram_addr == 4'd3) && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("clr_in_strobe", 32'(bif.we_n), 0);
    clr = 1'b1;
    #1;
    check("clr_we_n", 32'(bif.we_n), 1);
    check("clr_drive", 32'(bif.sram_drive), 0);
    check("clr_busy", 32'(bif.busy), 0);
    check("clr_addr", 32'(bif.sram_addr), 0);
    @(negedge clk);
    clr = 1'b0;
    mem_fill(8'hFF);
    run(1'b0, 8'h00, 1'b0, 0, cyc);
    check("post_clr_cycles", cyc, 98);
    check("post_clr_pass", 32'(bif.pass), 1);
    check("post_clr_err", 32'(bif.err_count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
